// File: rtl/pgen_pkg.sv
// Shared types for the pgen test-data generator: pattern modes and FSM states.
package pgen_pkg;

    typedef enum logic [1:0] {
        MODE_LFSR  = 2'd0,
        MODE_CNT   = 2'd1,
        MODE_WALK  = 2'd2,
        MODE_CONST = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Modes whose pattern degenerates on an all-zero word.
    function automatic logic needs_nonzero(mode_e m);
        return (m == MODE_LFSR) || (m == MODE_WALK);
    endfunction

endpackage

// File: rtl/pgen_if.sv
// Control/FIFO-write bundle between the enable logic, the generator and the FIFO.
interface pgen_if #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 16
);
    logic             en_gen;
    logic             en_wrk;
    logic             full;
    logic             start;
    logic             stop;
    logic [1:0]       mode;
    logic [WIDTH-1:0] seed;
    logic [CNTW-1:0]  burst_len;
    logic             wrreq;
    logic [WIDTH-1:0] data;
    logic             busy;
    logic             done;
    logic [CNTW-1:0]  wr_count;

    modport master (
        input  en_gen, en_wrk, full, start, stop, mode, seed, burst_len,
        output wrreq, data, busy, done, wr_count
    );

    modport slave (
        output en_gen, en_wrk, full, start, stop, mode, seed, burst_len,
        input  wrreq, data, busy, done, wr_count
    );
endinterface

// File: rtl/pgen_next.sv
// Combinational next-word logic for the four generator patterns.
module pgen_next
    import pgen_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(8'hEF)
) (
    input  mode_e            mode,
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] nxt
);

    always_comb begin
        nxt = cur;
        case (mode)
            MODE_LFSR:  nxt = {cur[WIDTH-2:0], ^(cur & POLY)};
            MODE_CNT:   nxt = cur + WIDTH'(1);
            MODE_WALK:  nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
            MODE_CONST: nxt = cur;
            default:    nxt = cur;
        endcase
    end

endmodule

// File: rtl/pgen.sv
// Burst test-data generator feeding a FIFO write port; never writes into a full FIFO.
module pgen
    import pgen_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(8'hEF),
    parameter int               CNTW  = 16
) (
    input  logic  clk,
    input  logic  rst,
    pgen_if.master bus
);

    state_e           state, state_nxt;
    mode_e            mode_q, mode_in;
    logic [CNTW-1:0]  len_q, cnt_q, cnt_inc;
    logic [WIDTH-1:0] data_q, data_nxt, seed_fix;
    logic             accept, last;

    assign mode_in  = mode_e'(bus.mode);
    assign seed_fix = (bus.seed == '0 && needs_nonzero(mode_in)) ? WIDTH'(1) : bus.seed;
    assign accept   = bus.wrreq;
    assign cnt_inc  = cnt_q + CNTW'(1);
    // Burst ends on the write that brings the count up to burst_len; 0 never matches.
    assign last     = (len_q != '0) && (cnt_inc == len_q);

    pgen_next #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_next (
        .mode (mode_q),
        .cur  (data_q),
        .nxt  (data_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if ((accept && last) || bus.stop) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.wrreq = 1'b0;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        case (state)
            RUN: begin
                bus.busy  = 1'b1;
                bus.wrreq = bus.en_gen & bus.en_wrk & ~bus.full;
            end
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= MODE_LFSR;
            len_q  <= '0;
            data_q <= '0;
            cnt_q  <= '0;
        end else if (state == IDLE && bus.start) begin
            mode_q <= mode_in;
            len_q  <= bus.burst_len;
            data_q <= seed_fix;
            cnt_q  <= '0;
        end else if (accept) begin
            data_q <= data_nxt;
            cnt_q  <= cnt_inc;
        end
    end

    assign bus.data     = data_q;
    assign bus.wr_count = cnt_q;

endmodule

// File: tb/tb_pgen.sv
// Directed bench for pgen: table of short bursts plus hand-written multi-cycle sequences.
module tb_pgen;
    import pgen_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pgen_if #(.WIDTH(8), .CNTW(16)) bus ();

    pgen #(.WIDTH(8), .POLY(8'hEF), .CNTW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef logic [7:0] words_t [10];
    typedef struct {
        logic [1:0]  mode;
        logic [7:0]  seed;
        logic [15:0] len;
        words_t      exp;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    int nchk = 0;
    int nfail = 0;
    logic [7:0] got [$];
    int ncyc, ndone, done_at;
    logic prev_wr = 1'b0, prev_busy = 1'b0;
    logic [7:0] prev_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic sample();
        if (prev_busy && bus.busy && !prev_wr)
            check("data_hold", 32'(bus.data), 32'(prev_data));
        if (bus.wrreq) got.push_back(bus.data);
        if (bus.done) begin
            ndone++;
            if (done_at < 0) done_at = ncyc;
        end
        prev_wr   = bus.wrreq;
        prev_busy = bus.busy;
        prev_data = bus.data;
        ncyc++;
    endtask

    // Inputs are set just after a negedge; outputs are sampled 1ns later, before the edge acts.
    task automatic cycle();
        #1;
        sample();
        @(negedge clk);
    endtask

    task automatic begin_burst(input logic [1:0] m, input logic [7:0] s, input logic [15:0] l);
        bus.mode      = m;
        bus.seed      = s;
        bus.burst_len = l;
        bus.start     = 1'b1;
        ncyc = 0; ndone = 0; done_at = -1;
        got.delete();
        cycle();
        bus.start = 1'b0;
        bus.seed  = 8'h5A;
    endtask

    task automatic run_to_done();
        for (int c = 0; c < 400 && done_at < 0; c++) cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{2'd0, 8'h01, 16'd4, '{8'h01, 8'h03, 8'h06, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[1] = '{2'd0, 8'h00, 16'd4, '{8'h01, 8'h03, 8'h06, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[2] = '{2'd1, 8'hFE, 16'd3, '{8'hFE, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[3] = '{2'd2, 8'h00, 16'd9, '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h00}};
        vecs[4] = '{2'd2, 8'h40, 16'd3, '{8'h40, 8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[5] = '{2'd3, 8'hA5, 16'd4, '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[6] = '{2'd1, 8'h00, 16'd1, '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[7] = '{2'd0, 8'h80, 16'd3, '{8'h80, 8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[8] = '{2'd3, 8'h00, 16'd2, '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[9] = '{2'd1, 8'h7E, 16'd5, '{8'h7E, 8'h7F, 8'h80, 8'h81, 8'h82, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};

        rst = 1'b1;
        bus.en_gen = 1'b1; bus.en_wrk = 1'b1; bus.full = 1'b0;
        bus.start = 1'b1; bus.stop = 1'b0; bus.mode = 2'd1;
        bus.seed = 8'h33; bus.burst_len = 16'd2;
        @(negedge clk); @(negedge clk);
        check("rst_data", 32'(bus.data), 32'h0);
        check("rst_wrreq", 32'(bus.wrreq), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_done", 32'(bus.done), 32'h0);
        check("rst_wr_count", 32'(bus.wr_count), 32'h0);
        bus.start = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            begin_burst(vecs[i].mode, vecs[i].seed, vecs[i].len);
            #1;
            check($sformatf("v%0d_busy_n1", i), 32'(bus.busy), 32'h1);
            check($sformatf("v%0d_seed_n1", i), 32'(bus.data), 32'(vecs[i].exp[0]));
            run_to_done();
            check($sformatf("v%0d_nwords", i), 32'(got.size()), 32'(vecs[i].len));
            for (int k = 0; k < got.size() && k < 10; k++)
                check($sformatf("v%0d_word%0d", i, k), 32'(got[k]), 32'(vecs[i].exp[k]));
            check($sformatf("v%0d_done_at", i), 32'(done_at), 32'(vecs[i].len) + 32'd1);
            check($sformatf("v%0d_ndone", i), 32'(ndone), 32'd1);
            check($sformatf("v%0d_wr_count", i), 32'(bus.wr_count), 32'(vecs[i].len));
            #1;
            check($sformatf("v%0d_idle_busy", i), 32'(bus.busy), 32'h0);
            @(negedge clk);
        end

        // Full stall: FIFO full for two cycles after the first write.
        begin_burst(2'd1, 8'hFE, 16'd3);
        cycle();
        bus.full = 1'b1;
        for (int s = 0; s < 2; s++) begin
            #1;
            check("stall_wrreq", 32'(bus.wrreq), 32'h0);
            check("stall_busy", 32'(bus.busy), 32'h1);
            cycle();
        end
        bus.full = 1'b0;
        run_to_done();
        check("stall_nwords", 32'(got.size()), 32'd3);
        if (got.size() == 3) begin
            check("stall_w0", 32'(got[0]), 32'hFE);
            check("stall_w1", 32'(got[1]), 32'hFF);
            check("stall_w2", 32'(got[2]), 32'h00);
        end
        check("stall_done_at", 32'(done_at), 32'd6);
        check("stall_ndone", 32'(ndone), 32'd1);
        @(negedge clk);

        // Continuous mode: 300 writes, ignored start mid-run, stop on the 300th write.
        begin_burst(2'd1, 8'h00, 16'd0);
        for (int c = 1; c <= 300; c++) begin
            bus.start = (c == 100);
            bus.mode  = (c == 100) ? 2'd3 : 2'd1;
            bus.seed  = 8'h77;
            bus.stop  = (c == 300);
            cycle();
        end
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        cycle();
        begin
            int bad = 0;
            for (int k = 0; k < got.size(); k++)
                if (got[k] !== 8'(k)) bad++;
            check("cont_seq_errors", 32'(bad), 32'd0);
        end
        check("cont_nwords", 32'(got.size()), 32'd300);
        check("cont_wr_count", 32'(bus.wr_count), 32'd300);
        check("cont_done_at", 32'(done_at), 32'd301);
        check("cont_ndone", 32'(ndone), 32'd1);
        cycle();
        check("cont_ndone_after", 32'(ndone), 32'd1);
        check("cont_idle_busy", 32'(bus.busy), 32'h0);

        // Enable gating: en_wrk toggles every 3 cycles, en_gen dropped once.
        begin_burst(2'd1, 8'h10, 16'd6);
        for (int c = 0; c < 40 && done_at < 0; c++) begin
            bus.en_wrk = ((c / 3) % 2) == 0;
            bus.en_gen = (c != 7);
            #1;
            if (bus.busy) check($sformatf("gate_c%0d", c), 32'(bus.wrreq), 32'(bus.en_wrk & bus.en_gen));
            cycle();
        end
        bus.en_wrk = 1'b1;
        bus.en_gen = 1'b1;
        check("gate_nwords", 32'(got.size()), 32'd6);
        for (int k = 0; k < got.size() && k < 6; k++)
            check($sformatf("gate_word%0d", k), 32'(got[k]), 32'h10 + 32'(k));
        check("gate_done_at", 32'(done_at), 32'd14);
        @(negedge clk);

        // Reset after the second write of a 5-word burst, then restart.
        begin_burst(2'd0, 8'h01, 16'd5);
        cycle();
        cycle();
        rst = 1'b1;
        #1;
        check("mrst_wrreq", 32'(bus.wrreq), 32'h0);
        check("mrst_busy", 32'(bus.busy), 32'h0);
        check("mrst_done", 32'(bus.done), 32'h0);
        check("mrst_data", 32'(bus.data), 32'h0);
        check("mrst_wr_count", 32'(bus.wr_count), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) cycle();
        check("mrst_no_done", 32'(ndone), 32'd0);
        begin_burst(2'd0, 8'h01, 16'd5);
        run_to_done();
        check("mrst_nwords", 32'(got.size()), 32'd5);
        if (got.size() == 5) begin
            check("mrst_w0", 32'(got[0]), 32'h01);
            check("mrst_w4", 32'(got[4]), 32'h18);
        end
        check("mrst_wr_count_end", 32'(bus.wr_count), 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
